// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver (8E1) with async FIFO into the clk domain
package uart_pkg;
  typedef enum logic [1:0] {SIMPLEX = 2'd0, HALFDUPLEX = 2'd1, FULLDUPLEX = 2'd2} mode_t;
  typedef struct packed {
    mode_t mode;
    logic  master;
    logic  flush_rx;
  } Config_t;
endpackage

// Gray-pointer dual-clock FIFO; flush drops everything the read side can see.
module fifo_async #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             rst_n,
  input  logic             wclk,
  input  logic             wflush_i,
  input  logic             wvalid_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             wfull_o,
  input  logic             rclk,
  input  logic             rflush_i,
  input  logic             rready_i,
  output logic             rvalid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rfull_o,
  output logic             rempty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wbin_q, wgray_q, rgray_s1_q, rgray_s2_q, wbin_d;
  logic [PW-1:0] rbin_q, rgray_q, wgray_s1_q, wgray_s2_q, rbin_d;
  logic          wr_en, rd_en;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign wbin_d  = wbin_q + PW'(1);
  assign wfull_o = (wgray_q == (rgray_s2_q ^ FULL_MASK));
  assign wr_en   = wvalid_i && !wfull_o && !wflush_i;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
      if (wr_en) begin
        wbin_q  <= wbin_d;
        wgray_q <= wbin_d ^ (wbin_d >> 1);
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en) mem_q[wbin_q[AW-1:0]] <= wdata_i;
  end

  assign rbin_d   = rbin_q + PW'(1);
  assign rempty_o = (rgray_q == wgray_s2_q);
  assign rfull_o  = ((rgray_q ^ FULL_MASK) == wgray_s2_q);
  assign rvalid_o = !rempty_o;
  assign rdata_o  = mem_q[rbin_q[AW-1:0]];
  assign rd_en    = rready_i && !rempty_o && !rflush_i;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
    end else begin
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
      if (rflush_i) begin
        rbin_q  <= gray2bin(wgray_s2_q);
        rgray_q <= wgray_s2_q;
      end else if (rd_en) begin
        rbin_q  <= rbin_d;
        rgray_q <= rbin_d ^ (rbin_d >> 1);
      end
    end
  end
endmodule

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              rx_d_i,
  input  logic              rx_rts_n_i,
  output logic              rx_cts_n_o,
  input  logic              rx_enable_i,
  output logic [7:0]        rx_d_o,
  output logic              rx_d_valid_o,
  input  logic              rx_d_ready_i,
  output logic              rx_full_o,
  output logic              rx_empty_o,
  output logic              rx_parity_err_o,
  output logic              rx_frame_err_o,
  output logic              rx_overrun_o,
  input  uart_pkg::Config_t uart_config_i
);
  import uart_pkg::*;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d, enq_q, enq_d;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [1:0]    line_q, flush_sck_q, flush_clk_q;
  logic [2:0]    flag_s1_q, flag_s2_q;
  logic          cts_n_q, s, active, flush_raw, flush_s, wfull, at_mid, at_end;

  assign s         = line_q[1];
  assign flush_s   = flush_sck_q[1];
  assign active    = (uart_config_i.mode == FULLDUPLEX) || rx_enable_i;
  assign flush_raw = uart_config_i.flush_rx ||
                     (uart_config_i.mode == SIMPLEX && uart_config_i.master);
  assign at_mid    = (cnt_q == CW'(OVERSAMPLE / 2 - 1));
  assign at_end    = (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    enq_d   = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q || (enq_q && wfull);
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (active && !s) state_d = RX_START;
      end
      RX_START: if (at_mid) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (at_end) begin
        cnt_d  = '0;
        data_d = {s, data_q[7:1]};
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = RX_PARITY;
      end
      RX_PARITY: if (at_end) begin
        cnt_d   = '0;
        par_d   = s;
        state_d = RX_STOP;
      end
      RX_STOP: if (at_end) begin
        // Back to idle on the stop sample so a back-to-back start is seen next cycle.
        cnt_d   = '0;
        state_d = RX_IDLE;
        if (!s) ferr_d = 1'b1;
        if (par_q != ^data_q) perr_d = 1'b1;
        enq_d   = s && (par_q == ^data_q);
      end
      default: state_d = RX_IDLE;
    endcase
    if (flush_s) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
      enq_d   = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      enq_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      line_q      <= 2'b11;
      flush_sck_q <= 2'b00;
      cts_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      par_q       <= par_d;
      enq_q       <= enq_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      line_q      <= {line_q[0], rx_d_i};
      flush_sck_q <= {flush_sck_q[0], flush_raw};
      cts_n_q     <= !(active && !rx_rts_n_i && !wfull);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_clk_q <= 2'b00;
      flag_s1_q   <= '0;
      flag_s2_q   <= '0;
    end else begin
      flush_clk_q <= {flush_clk_q[0], flush_raw};
      flag_s1_q   <= {ovr_q, ferr_q, perr_q};
      flag_s2_q   <= flag_s1_q;
    end
  end

  assign rx_cts_n_o      = cts_n_q;
  assign rx_parity_err_o = flag_s2_q[0];
  assign rx_frame_err_o  = flag_s2_q[1];
  assign rx_overrun_o    = flag_s2_q[2];

  fifo_async #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .rst_n    (rst_n),
    .wclk     (sck),
    .wflush_i (flush_s),
    .wvalid_i (enq_q),
    .wdata_i  (data_q),
    .wfull_o  (wfull),
    .rclk     (clk),
    .rflush_i (flush_clk_q[1]),
    .rready_i (rx_d_ready_i),
    .rvalid_o (rx_d_valid_o),
    .rdata_o  (rx_d_o),
    .rfull_o  (rx_full_o),
    .rempty_o (rx_empty_o)
  );
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the UART transmitter on the same link. It oversamples the serial line and deframes 11-bit frames: 1 start (0), 8 data LSB-first, 1 even-parity bit, 1 stop (1). It checks parity and stop bit, then pushes good bytes through an async FIFO from the sample clock domain (sck) to the system clock domain (clk). It drives the CTS side of the RTS/CTS handshake.

Parameters:
OVERSAMPLE, 16, sck cycles per bit period; even, >=4
FIFO_DEPTH, 8, RX fifo_async buffer_size (data_size fixed 8)

Ports:
clk  input  1  system clock; FIFO dequeue side
rst_n  input  1  reset, asynchronous, active-low, all domains
sck  input  1  sample clock = OVERSAMPLE x bit rate; same generator as the TX bit clock
rx_d_i  input  1  serial line, asynchronous to sck
rx_rts_n_i  input  1  remote RTS, active-low
rx_cts_n_o  output  1  CTS to remote, active-low
rx_enable_i  input  1  receive enable for non-FULLDUPLEX modes
rx_d_o  output  8  FIFO head byte (clk domain)
rx_d_valid_o  output  1  head valid (clk domain)
rx_d_ready_i  input  1  pop; byte consumed when valid && ready at posedge clk
rx_full_o  output  1  FIFO full
rx_empty_o  output  1  FIFO empty
rx_parity_err_o  output  1  sticky parity error, clk domain
rx_frame_err_o  output  1  sticky stop-bit error, clk domain
rx_overrun_o  output  1  sticky overrun, clk domain
uart_config_i  input  Config_t  uses mode, master, flush_rx

Behaviour:
- Reset: state RX_IDLE, counters 0, shift reg 0, line synchronizer = 1, rx_cts_n_o=1, all error flags 0, FIFO empty (rx_d_valid_o=0, rx_empty_o=1, rx_full_o=0).
- rx_d_i passes through a 2-FF synchronizer in sck (reset 1). All line decisions use the synchronized value s.
- active = (mode==FULLDUPLEX || rx_enable_i). Registered in sck: rx_cts_n_o = !(active && !rx_rts_n_i && !fifo_full).
- FIFO flush = flush_rx || (mode==SIMPLEX && master). Flush also clears the three sticky flags and forces RX_IDLE.
- FSM (sck domain). States: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
  - RX_IDLE: when active && s==0, go to RX_START with cnt=0. s==0 while inactive is ignored.
  - RX_START: cnt increments each sck. At cnt==OVERSAMPLE/2-1 (mid start bit), go to RX_DATA with cnt=0 and bit index 0 if s==0; otherwise it is a glitch: go to RX_IDLE with no flag.
  - RX_DATA: cnt counts 0..OVERSAMPLE-1. At cnt==OVERSAMPLE-1, sample s into data[idx], LSB first. After idx 7, go to RX_PARITY.
  - RX_PARITY: one bit period, then sample the parity bit p, go to RX_STOP.
  - RX_STOP: one bit period, then sample the stop bit and go to RX_IDLE in the same cycle. This allows back-to-back frames: the next start edge is accepted from the following sck.
- Net result: the first sample is taken OVERSAMPLE/2 sck after start detection. Each later sample is OVERSAMPLE sck after the previous one. The stop sample falls at start detect + OVERSAMPLE/2 + 10*OVERSAMPLE.
- Parity check: expected = XOR(data[7:0]). Mismatch sets parity_err.
- Stop check: stop==0 sets frame_err. A parity or frame error discards the byte (no enqueue).
- Good frame: enq_valid pulses 1 sck cycle, in the cycle after the stop sample, with the data byte. If the FIFO is full at that point, the byte is dropped and overrun is set; FIFO contents are unchanged.
- Sticky flags are set in sck and cleared only by flush or reset. Each reaches clk via a 2-FF synchronizer (2-3 clk latency).
- rx_d_valid_o / rx_d_o follow fifo_async deq semantics. Popping while empty has no effect. Simultaneous enqueue and dequeue is handled by fifo_async.
- Deassertion of active mid-frame does not abort the frame; it only blocks new start detection.
- Async reset mid-frame drops the partial frame. After release the FSM waits in RX_IDLE for a new falling edge; a line already low is treated as a start.

Test Plan:
- Frame 0xA5, parity 0, stop 1, OVERSAMPLE=16 -> one enqueue; rx_d_o=0xA5, rx_d_valid_o=1; all flags 0.
- Frame 0x01 with parity bit 0 (expected 1) -> no enqueue; rx_parity_err_o=1 and stays 1 until flush_rx is pulsed, then 0.
- Frame 0x3C with stop bit 0 -> no enqueue; rx_frame_err_o=1.
- 1-sck low glitch (shorter than OVERSAMPLE/2) on an idle line -> FSM returns to RX_IDLE; no enqueue, no flags.
- 9 back-to-back good frames 0x10..0x18 with no pops, FIFO_DEPTH=8 -> 0x10..0x17 stored; rx_full_o=1; rx_cts_n_o=1 while full; 0x18 dropped; rx_overrun_o=1; popping yields 0x10..0x17 in order.
- mode=SIMPLEX, rx_enable_i=0, line frame 0x55 -> ignored. Set rx_enable_i=1, rx_rts_n_i=0 -> rx_cts_n_o=0, and the next frame 0x55 is received.
